instr_encoder: RTL and testbench

Pipelined RV32I instruction encoder: accepts symbolic ALU-class instruction requests (operation, register indices, immediate) over a valid/ready handshake. Emits the packed 32-bit instruction word together with a sequential word address for loading instruction memory. It is the inverse of the core's ALU-control decoder, so any word it emits decodes back to the requested ALU operation. It sits between the test/boot loader and the instruction-memory write port.

---
 rtl/instr_enc_pkg.sv | 36 +++
 rtl/instr_enc_if.sv | 33 +++
 rtl/instr_enc_fields.sv | 83 ++++++++
 rtl/instr_encoder.sv | 80 ++++++++
 tb/tb_instr_encoder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_enc_pkg.sv
// instr_encoder shared types: symbolic ops, opcodes and funct fields.
// Same opcode/funct values the ALU-control decoder matches on.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_ADDI = 3'd4,
    OP_ANDI = 3'd5,
    OP_ORI  = 3'd6,
    OP_BEQ  = 3'd7
  } enc_op_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    enc_op_t     op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } enc_req_t;

endpackage

// File: rtl/instr_enc_if.sv
// Request/response handshake bundle between loader and instr_encoder.
// master = loader side, slave = encoder side.
interface instr_enc_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [12:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic              clr_err;

  modport master (
    output in_valid, in_op, in_rd, in_rs1,
    output in_rs2, in_imm, out_ready, clr_err,
    input  in_ready, out_valid, out_instr,
    input  out_addr, err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1,
    input  in_rs2, in_imm, out_ready, clr_err,
    output in_ready, out_valid, out_instr,
    output out_addr, err
  );
endinterface

// File: rtl/instr_enc_fields.sv
// Combinational request-to-word packer with illegal-request detection.
// Branch packing only exists when INSTR_ENC_BEQ_EN is defined.
module instr_enc_fields
  import instr_enc_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word,
  output logic        illegal
);

  logic [6:0] f7;
  logic [2:0] f3;
  logic       is_r;
  logic       is_i;
  logic       is_b;

  always_comb begin
    f7   = F7_BASE;
    f3   = F3_ADD;
    is_r = 1'b0;
    is_i = 1'b0;
    is_b = 1'b0;
    unique case (req.op)
      OP_ADD: is_r = 1'b1;
      OP_SUB: begin
        is_r = 1'b1;
        f7   = F7_SUB;
      end
      OP_AND: begin
        is_r = 1'b1;
        f3   = F3_AND;
      end
      OP_OR: begin
        is_r = 1'b1;
        f3   = F3_OR;
      end
      OP_ADDI: is_i = 1'b1;
      OP_ANDI: begin
        is_i = 1'b1;
        f3   = F3_AND;
      end
      OP_ORI: begin
        is_i = 1'b1;
        f3   = F3_OR;
      end
      OP_BEQ: begin
        is_b = 1'b1;
        f3   = F3_BEQ;
      end
      default: is_r = 1'b0;
    endcase
  end

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      is_r: word = {f7, req.rs2, req.rs1,
                    f3, req.rd, OPC_RTYPE};
      is_i: word = {req.imm[11:0], req.rs1,
                    f3, req.rd, OPC_ITYPE};
`ifdef INSTR_ENC_BEQ_EN
      // Branch offsets are halfword-aligned.
      is_b: begin
        illegal = req.imm[0];
        word    = {req.imm[12], req.imm[10:5],
                   req.rs2, req.rs1, f3,
                   req.imm[4:1], req.imm[11],
                   OPC_BRANCH};
      end
`else
      is_b: illegal = 1'b1;
`endif
      default: word = '0;
    endcase
  end

`ifndef INSTR_ENC_BEQ_EN
  logic unused_imm12;
  assign unused_imm12 = req.imm[12];
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I ALU-class encoder: one output register, word counter, sticky err.
// Optional BEQ support via INSTR_ENC_BEQ_EN.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  instr_enc_if.slave bus
);

  localparam int IDX_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  enc_req_t         req;
  logic [31:0]      word;
  logic             illegal;
  logic [31:0]      instr_q;
  logic             valid_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic             rdy;
  logic             acc;
  logic             fire;

  assign req = '{
    op:  enc_op_t'(bus.in_op),
    rd:  bus.in_rd,
    rs1: bus.in_rs1,
    rs2: bus.in_rs2,
    imm: bus.in_imm
  };

  instr_enc_fields u_fields (
    .req     (req),
    .word    (word),
    .illegal (illegal)
  );

  assign rdy  = !valid_q || bus.out_ready;
  assign acc  = bus.in_valid && rdy;
  assign fire = valid_q && bus.out_ready;

  assign idx_nxt = (idx_q == IDX_W'(DEPTH - 1))
                 ? '0 : idx_q + 1'b1;

  // An accepted illegal request leaves the register empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
    end else if (acc) begin
      valid_q <= !illegal;
      if (!illegal) instr_q <= word;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else if (fire) idx_q <= idx_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (acc && illegal) err_q <= 1'b1;
    else if (bus.clr_err) err_q <= 1'b0;
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = ADDR_W'({idx_q, 2'b00});
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder with an output scoreboard.
// Build with or without INSTR_ENC_BEQ_EN.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst_n;

  instr_enc_if #(.ADDR_W(32)) bus ();

  instr_encoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_chk;
  int          n_fail;
  logic [31:0] sb[$];
  int          widx;
  logic [31:0] cur_exp;
  logic        cur_ill;
  vec_t        tbl[8];
  vec_t        ill_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Pop before push: a same-cycle handshake drains the old word.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      widx = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got %h expected none",
                   bus.out_instr);
        end else begin
          chk("out_instr", bus.out_instr, sb.pop_front());
          chk("out_addr", bus.out_addr,
              32'((widx % DEPTH) * 4));
          widx++;
        end
      end
      if (bus.in_valid && bus.in_ready && !cur_ill)
        sb.push_back(cur_exp);
    end
  end

  task automatic send(input vec_t v);
    int n;
    n            = 0;
    bus.in_op    = v.op;
    bus.in_rd    = v.rd;
    bus.in_rs1   = v.rs1;
    bus.in_rs2   = v.rs2;
    bus.in_imm   = v.imm;
    cur_exp      = v.exp;
    cur_ill      = v.ill;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    widx    = 0;
    cur_exp = '0;
    cur_ill = 1'b0;

    tbl[0] = '{3'd0, 5'd3, 5'd1, 5'd2,
               13'h0000, 32'h002081B3, 1'b0};
    tbl[1] = '{3'd1, 5'd5, 5'd6, 5'd7,
               13'h0000, 32'h407302B3, 1'b0};
    tbl[2] = '{3'd4, 5'd1, 5'd0, 5'd0,
               13'h1FFF, 32'hFFF00093, 1'b0};
    tbl[3] = '{3'd5, 5'd2, 5'd1, 5'd31,
               13'h000F, 32'h00F0F113, 1'b0};
    tbl[4] = '{3'd2, 5'd4, 5'd5, 5'd6,
               13'h0000, 32'h0062F233, 1'b0};
    tbl[5] = '{3'd3, 5'd31, 5'd30, 5'd29,
               13'h0000, 32'h01DF6FB3, 1'b0};
    tbl[6] = '{3'd6, 5'd10, 5'd11, 5'd3,
               13'h07FF, 32'h7FF5E513, 1'b0};
    tbl[7] = '{3'd4, 5'd7, 5'd8, 5'd0,
               13'h1800, 32'h80040393, 1'b0};
`ifdef INSTR_ENC_BEQ_EN
    ill_v  = '{3'd7, 5'd0, 5'd1, 5'd2,
               13'h0007, 32'h0, 1'b1};
`else
    ill_v  = '{3'd7, 5'd0, 5'd1, 5'd2,
               13'h0008, 32'h0, 1'b1};
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    bus.clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back, one word per cycle; addresses wrap at DEPTH.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      if (i == 1)
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    end

`ifdef INSTR_ENC_BEQ_EN
    send('{3'd7, 5'd9, 5'd1, 5'd2,
           13'h0008, 32'h00208463, 1'b0});
    send('{3'd7, 5'd0, 5'd0, 5'd0,
           13'h1FFC, 32'hFE000EE3, 1'b0});
`endif

    // Backpressure: second request waits while output holds.
    idle(2);
    bus.out_ready = 1'b0;
    send(tbl[0]);
    fork
      send(tbl[1]);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_instr", bus.out_instr, tbl[0].exp);
          chk("stall_addr", bus.out_addr,
              32'((widx % DEPTH) * 4));
        end
        bus.out_ready = 1'b1;
      end
    join

    // Illegal request accepted while the register drains.
    idle(2);
    bus.out_ready = 1'b0;
    send(tbl[1]);
    fork
      send(ill_v);
      begin
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    chk("ill_valid", 32'(bus.out_valid), 32'd0);
    chk("ill_err", 32'(bus.err), 32'd1);
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    chk("clr_err", 32'(bus.err), 32'd0);

    // Set wins over a simultaneous clear.
    bus.clr_err = 1'b1;
    send(ill_v);
    bus.clr_err = 1'b0;
    chk("set_wins", 32'(bus.err), 32'd1);
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    chk("clr_err2", 32'(bus.err), 32'd0);

    // Counter must not have moved for the illegal requests.
    send(tbl[2]);
    send(tbl[5]);

    // Reset with a word pending.
    idle(2);
    bus.out_ready = 1'b0;
    send(tbl[3]);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_addr", bus.out_addr,
        32'((widx % DEPTH) * 4));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_addr", bus.out_addr, 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(tbl[4]);
    send(tbl[6]);

    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
